// File: rtl/fb_pkg.sv
// Shared framebuffer SPRAM widths, last address and arbiter state encoding.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fb_pkg;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int MASK_W = 4;
  localparam logic [ADDR_W-1:0] LAST_ADDR = 14'd16383;

  typedef enum logic [1:0] {
    ST_ARB      = 2'd0,
    ST_FORCE_WR = 2'd1,
    ST_CLEAR    = 2'd2
  } arb_state_t;
endpackage

// File: rtl/fb_spram_arb_if.sv
// Bundle of read/write/clear requester and SPRAM signals around the arbiter.
// Latency: none (wires only).
// Backpressure: req is held until gnt; the slave side owns every gnt.
interface fb_spram_arb_if;
  import fb_pkg::*;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [MASK_W-1:0] wr_mask;
  logic              wr_gnt;

  logic              clr_start;
  logic              clr_busy;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [MASK_W-1:0] ram_mask;
  logic              ram_wren;
  logic              ram_cs;
  logic [DATA_W-1:0] ram_dout;

  // Arbiter side.
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_mask, clr_start, ram_dout,
    output rd_gnt, rd_data, rd_valid, wr_gnt, clr_busy,
           ram_addr, ram_din, ram_mask, ram_wren, ram_cs
  );

  // Requester and RAM side.
  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_mask, clr_start, ram_dout,
    input  rd_gnt, rd_data, rd_valid, wr_gnt, clr_busy,
           ram_addr, ram_din, ram_mask, ram_wren, ram_cs
  );
endinterface

// File: rtl/fb_arb_stats.sv
// Saturating counters of write-stall cycles and forced write grants.
// Latency: counts update on the clock edge after the event.
// Backpressure: none; observes only.
module fb_arb_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_inc,
  input  logic        force_inc,
  output logic [15:0] stall_cnt,
  output logic [15:0] force_cnt
);
  // Each counter sticks at all-ones until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      force_cnt <= '0;
    end else begin
      if (stall_inc && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (force_inc && force_cnt != 16'hFFFF) force_cnt <= force_cnt + 16'd1;
    end
  end
endmodule

// File: rtl/fb_spram_arb.sv
// Framebuffer SPRAM arbiter: read priority, bounded read streaks, clear sweep; FB_ARB_STATS_EN adds stall/force counters.
// Latency: grants and ram_* are combinational; rd_valid/rd_data arrive 1 cycle after rd_gnt.
// Backpressure: requesters hold req until gnt; writes wait behind reads for at most MAX_RD_BURST grants.
module fb_spram_arb
  import fb_pkg::*;
#(
  parameter int unsigned       MAX_RD_BURST = 8,
  parameter logic [DATA_W-1:0] CLR_VALUE    = 16'h0000
) (
  input logic           vga_ck,
  input logic           rst,
  fb_spram_arb_if.slave bus
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   force_cnt
`endif
);
  localparam logic [7:0] BURST_LIM = 8'(MAX_RD_BURST);

  arb_state_t        state;
  logic [7:0]        streak;
  logic [7:0]        streak_inc;
  logic [ADDR_W-1:0] clr_ptr;
  logic              rd_valid_q;
  logic              clr_busy_q;
  logic              rd_gnt;
  logic              wr_gnt;
  logic              clr_wr;

  assign streak_inc = streak + 8'd1;

  // Grant selection: at most one of read, write or clear write per cycle, none in reset.
  always_comb begin
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
    clr_wr = 1'b0;
    if (!rst) begin
      case (state)
        ST_ARB: begin
          rd_gnt = bus.rd_req;
          wr_gnt = bus.wr_req & ~bus.rd_req;
        end
        ST_FORCE_WR: wr_gnt = bus.wr_req;
        ST_CLEAR: begin
          rd_gnt = bus.rd_req;
          clr_wr = ~bus.rd_req;
        end
        default: ;
      endcase
    end
  end

  // SPRAM port steering from whichever source holds the grant.
  always_comb begin
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    bus.ram_mask = '0;
    bus.ram_wren = 1'b0;
    bus.ram_cs   = 1'b0;
    if (rd_gnt) begin
      bus.ram_addr = bus.rd_addr;
      bus.ram_cs   = 1'b1;
    end else if (wr_gnt) begin
      bus.ram_addr = bus.wr_addr;
      bus.ram_din  = bus.wr_data;
      bus.ram_mask = bus.wr_mask;
      bus.ram_wren = 1'b1;
      bus.ram_cs   = 1'b1;
    end else if (clr_wr) begin
      bus.ram_addr = clr_ptr;
      bus.ram_din  = CLR_VALUE;
      bus.ram_mask = 4'hF;
      bus.ram_wren = 1'b1;
      bus.ram_cs   = 1'b1;
    end
  end

  // Arbitration FSM with read streak, clear pointer and registered status outputs.
  always_ff @(posedge vga_ck) begin
    if (rst) begin
      state      <= ST_ARB;
      streak     <= '0;
      clr_ptr    <= '0;
      rd_valid_q <= 1'b0;
      clr_busy_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_gnt;
      case (state)
        ST_ARB: begin
          if (bus.clr_start) begin
            state      <= ST_CLEAR;
            clr_ptr    <= '0;
            clr_busy_q <= 1'b1;
            streak     <= '0;
          end else if (!bus.wr_req || wr_gnt) begin
            streak <= '0;
          end else if (rd_gnt) begin
            // A write is waiting behind this read.
            streak <= streak_inc;
            if (streak_inc == BURST_LIM) state <= ST_FORCE_WR;
          end
        end
        ST_FORCE_WR: begin
          // Leaves after one cycle whether or not the writer was still asking.
          streak <= '0;
          if (bus.clr_start) begin
            state      <= ST_CLEAR;
            clr_ptr    <= '0;
            clr_busy_q <= 1'b1;
          end else begin
            state <= ST_ARB;
          end
        end
        ST_CLEAR: begin
          if (clr_wr) begin
            clr_ptr <= clr_ptr + 1'b1;
            if (clr_ptr == LAST_ADDR) begin
              state      <= ST_ARB;
              clr_busy_q <= 1'b0;
            end
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

  assign bus.rd_gnt   = rd_gnt;
  assign bus.wr_gnt   = wr_gnt;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = bus.ram_dout;
  assign bus.clr_busy = clr_busy_q;

`ifdef FB_ARB_STATS_EN
  logic stall_inc;
  logic force_inc;
  assign stall_inc = bus.wr_req & ~wr_gnt;
  assign force_inc = wr_gnt & (state == ST_FORCE_WR);

  fb_arb_stats u_stats (
    .clk       (vga_ck),
    .rst       (rst),
    .stall_inc (stall_inc),
    .force_inc (force_inc),
    .stall_cnt (stall_cnt),
    .force_cnt (force_cnt)
  );
`endif
endmodule
